reg_op_engine: RTL and testbench
================================

# reg_op_engine

Multi-cycle register-to-register execution sequencer paired with the 16x32 register file. Accepts one ALU command at a time over a valid/ready handshake and drives the register file's two asynchronous read ports. It computes ADD/SUB/AND/OR with NZCV flags, then writes the result back through the register file's synchronous write port. Sits between instruction decode (upstream) and the register file/ALU datapath, as the first sequential execute stage of the MiniRISC core.

## Interface
- WIDTH, 32, data width; must match register file word width
- ADDR_W, 4, register address width (16 registers)

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle; command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- cmd_wb  in  1  1 = write result to rd; 0 = flags only (compare/test)
- cmd_rd, cmd_rn, cmd_rm  in  ADDR_W each  destination, operand A, operand B register addresses
- read_addr1, read_addr2  out  ADDR_W  to register file (rn, rm)
- read_data1, read_data2  in  WIDTH  from register file, asynchronous
- wr_en  out  1  register file write enable
- write_addr  out  ADDR_W  equals latched rd
- write_data  out  WIDTH  latched result
- done  out  1  one-cycle pulse: command retired
- flags  out  4  {N,Z,C,V}, registered

## Operation
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE; no other transitions except reset.
- IDLE: cmd_ready=1. On handshake, latch op, wb, rd, rn, rm; go to READ. Without a handshake, stay in IDLE.
- READ: read_addr1=rn, read_addr2=rm; capture read_data1/2 into operand registers at the edge.
- EXEC: compute result and NZCV from the operand registers; latch both.
- WB: wr_en = wb; write_addr=rd; write_data=result; flags register updates at this edge; done=1.
- read_addr1/2 hold the latched rn/rm in all states, and are 0 after reset.
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry out; V = operands with the same sign giving a result of the other sign.
  - SUB: result = A + ~B + 1; C = no borrow (A >= B unsigned); V = signed overflow.
  - AND/OR: C=0, V=0.
  - All ops: N = result[WIDTH-1]; Z = (result == 0).
- rd may equal rn or rm. The operands are captured before write-back, so the old value is used.
- Back-to-back commands are not pipelined. A following command reads registers after the previous write commits, so no hazard logic is needed.

## Timing
- Handshake at edge N. READ occupies cycle N+1, EXEC N+2, WB N+3. Register write and flags commit at the end of N+3. cmd_ready returns to 1 in N+4.
- Throughput: one command per 4 cycles.
- cmd_ready and done are decoded from state and gated with !reset.
- wr_en is gated with !reset, so a reset asserted during WB produces no write.
- Reset values (the cycle after reset is sampled): state IDLE, flags 0000, wr_en 0, done 0, cmd_ready 1, write_addr 0, write_data 0, latched fields 0.
- Reset mid-operation (READ/EXEC/WB) aborts the command. No write occurs, flags stay cleared, and no done pulse is produced.
- cmd_valid during a non-IDLE state is ignored. The upstream stage must hold the command until it sees ready.
- cmd_valid and reset asserted together: reset wins; the command is not accepted.

## Structure
- Package reg_op_pkg:
  - op_t enum (OP_ADD, OP_SUB, OP_AND, OP_OR)
  - state_t enum (S_IDLE, S_READ, S_EXEC, S_WB)
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One combinational sub-module, alu_core: inputs a, b, op; outputs result and NZCV. It is reused later by the pipelined core.
- The top module holds the FSM, the latched command fields, the operand registers and the result/flag registers.

## Test plan
- Reset, then ADD r3 = r1 + r2 with r1=5, r2=7, wb=1. Required: wr_en in the 3rd cycle after the handshake, write_addr=3, write_data=12, flags=0000, done once, ready back next cycle.
- SUB with A=3, B=5. Required: result 0xFFFFFFFE, flags N=1 Z=0 C=0 V=0. SUB with A=5, B=5: result 0, flags Z=1 C=1.
- ADD 0x7FFFFFFF + 1. Required: result 0x80000000, N=1 V=1 C=0. ADD 0xFFFFFFFF + 1: result 0, Z=1 C=1.
- Compare with wb=0, AND of 0xF0 and 0x0F. Required: wr_en never asserts, flags Z=1, done pulses, register contents unchanged.
- Hold cmd_valid continuously with three commands, the third using rd=rn of a prior write. Required: exactly 4 cycles per command and the updated value is read.
- Assert reset during EXEC, then during WB. Required: no write in either case, done=0, flags=0000, cmd_ready=1 the next cycle.

Source files
------------

// File: rtl/reg_op_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : reg_op_pkg
// Description : Shared types and constants for the register-to-register
//               execution sequencer and its ALU core.
//               - op_t    : ALU operation encoding (matches cmd_op)
//               - state_t : sequencer FSM state encoding
//               - FLAG_*  : bit positions of N/Z/C/V inside a 4-bit flag word
// Revision    : 1.0 - initial release
// ============================================================================
package reg_op_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU: ADD / SUB / AND / OR with NZCV.
//               SUB is performed as a + ~b + 1, so C means "no borrow".
// Ports       : a, b   in  WIDTH  operands
//               op     in  2      operation (op_t encoding)
//               result out WIDTH  a op b, modulo 2^WIDTH
//               nzcv   out 4      {N,Z,C,V}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import reg_op_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv
);

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  always_comb begin
    // One adder serves both ADD and SUB; SUB inverts b and injects a carry.
    w_cin   = (op == OP_SUB);
    w_b_eff = w_cin ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    case (op_t'(op))
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        // Overflow: both adder inputs share a sign the result does not.
        w_v   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      default: w_res = '0;
    endcase
    result         = w_res;
    nzcv           = 4'b0000;
    nzcv[FLAG_N]   = w_res[WIDTH-1];
    nzcv[FLAG_Z]   = (w_res == '0);
    nzcv[FLAG_C]   = w_c;
    nzcv[FLAG_V]   = w_v;
  end

endmodule
`default_nettype wire

// File: rtl/reg_op_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : reg_op_engine
// Description : Four-state execution sequencer (IDLE->READ->EXEC->WB) that
//               reads two registers, runs one ALU op, and writes the result
//               back into the register file. One command per 4 cycles.
// Ports       : clk, reset                   clock, sync active-high reset
//               cmd_valid/cmd_ready          command handshake
//               cmd_op, cmd_wb               operation, write-back enable
//               cmd_rd, cmd_rn, cmd_rm       dest / operand register indices
//               read_addr1/2, read_data1/2   async register file read ports
//               wr_en, write_addr, write_data register file write port
//               done                         one-cycle retire pulse
//               flags                        registered {N,Z,C,V}
// Revision    : 1.0 - initial release
// ============================================================================
module reg_op_engine
  import reg_op_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_wb,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rn,
  input  logic [ADDR_W-1:0] cmd_rm,
  output logic [ADDR_W-1:0] read_addr1,
  output logic [ADDR_W-1:0] read_addr2,
  input  logic [WIDTH-1:0]  read_data1,
  input  logic [WIDTH-1:0]  read_data2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic              done,
  output logic [3:0]        flags
);

  state_t            r_state;
  logic [1:0]        r_op;
  logic              r_wb;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rn;
  logic [ADDR_W-1:0] r_rm;
  logic [WIDTH-1:0]  r_opa;
  logic [WIDTH-1:0]  r_opb;
  logic [WIDTH-1:0]  r_result;
  logic [3:0]        r_nzcv;
  logic [3:0]        r_flags;

  logic [WIDTH-1:0]  w_result;
  logic [3:0]        w_nzcv;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (r_opa),
    .b      (r_opb),
    .op     (r_op),
    .result (w_result),
    .nzcv   (w_nzcv)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_wb     <= 1'b0;
      r_rd     <= '0;
      r_rn     <= '0;
      r_rm     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_nzcv   <= 4'b0000;
      r_flags  <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          // cmd_ready is simply "idle and not in reset", so valid alone
          // completes the handshake here.
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_wb    <= cmd_wb;
            r_rd    <= cmd_rd;
            r_rn    <= cmd_rn;
            r_rm    <= cmd_rm;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // Operands are captured before any write-back, so rd==rn/rm
          // naturally sees the old register value.
          r_opa   <= read_data1;
          r_opb   <= read_data2;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= w_result;
          r_nzcv   <= w_nzcv;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_flags <= r_nzcv;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake/strobe outputs are masked by reset so an abort in WB can
  // neither write the register file nor signal retirement.
  assign cmd_ready  = (r_state == S_IDLE) && !reset;
  assign done       = (r_state == S_WB) && !reset;
  assign wr_en      = (r_state == S_WB) && r_wb && !reset;
  assign read_addr1 = r_rn;
  assign read_addr2 = r_rm;
  assign write_addr = r_rd;
  assign write_data = r_result;
  assign flags      = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_reg_op_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_reg_op_engine
// Description : Directed self-checking bench for reg_op_engine. Contains a
//               16x32 register file model (async read, sync write) that the
//               DUT drives; expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_op_engine;
  import reg_op_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_wb;
  logic [3:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [3:0]  read_addr1, read_addr2;
  logic [31:0] read_data1, read_data2;
  logic        wr_en;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        done;
  logic [3:0]  flags;

  logic [31:0] rf [16];
  logic        pre_we;
  logic [3:0]  pre_a;
  logic [31:0] pre_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_op_engine #(.WIDTH(32), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_wb     (cmd_wb),
    .cmd_rd     (cmd_rd),
    .cmd_rn     (cmd_rn),
    .cmd_rm     (cmd_rm),
    .read_addr1 (read_addr1),
    .read_addr2 (read_addr2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .wr_en      (wr_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .done       (done),
    .flags      (flags)
  );

  // Register file model: bench preload port has priority over the DUT port.
  always @(posedge clk) begin
    if (pre_we) rf[pre_a] <= pre_d;
    else if (wr_en) rf[write_addr] <= write_data;
  end
  assign read_data1 = rf[read_addr1];
  assign read_data2 = rf[read_addr2];

  function automatic logic [31:0] init_val(input int i);
    case (i)
      1:  return 32'd5;
      2:  return 32'd7;
      4:  return 32'd3;
      5:  return 32'd5;
      6:  return 32'h7FFF_FFFF;
      7:  return 32'd1;
      8:  return 32'hFFFF_FFFF;
      9:  return 32'h0000_00F0;
      10: return 32'h0000_000F;
      default: return 32'd0;
    endcase
  endfunction

  // Drives one command at a negedge and records what the DUT does during the
  // following five cycles (k=1 is the cycle after the handshake edge).
  task automatic issue(input logic [1:0] op, input logic wb,
                       input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                       output int wr_cyc, output logic [3:0] wa, output logic [31:0] wd,
                       output int done_cnt, output int done_cyc, output int rdy_cyc,
                       output logic [3:0] fl);
    wr_cyc = 0; wa = '0; wd = '0; done_cnt = 0; done_cyc = 0; rdy_cyc = 0;
    @(negedge clk);
    cmd_op = op; cmd_wb = wb; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (wr_cyc == 0) wr_cyc = k;
        wa = write_addr;
        wd = write_data;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      if (cmd_ready === 1'b1 && rdy_cyc == 0) rdy_cyc = k;
    end
    fl = flags;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1;
    cmd_op = 2'b00; cmd_wb = 1'b1; cmd_rd = 4'd3; cmd_rn = 4'd1; cmd_rm = 4'd2;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_a = 4'(i); pre_d = init_val(i);
    end
    @(negedge clk);
    pre_we = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", cmd_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    // Valid was high through every reset edge; it must not have been taken.
    reset = 1'b0; cmd_valid = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    checks++; if (write_addr !== 4'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", write_addr); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", write_data); end
    checks++; if (read_addr1 !== 4'd0 || read_addr2 !== 4'd0) begin
      errors++; $display("FAIL reset_raddr got %0d/%0d want 0/0", read_addr1, read_addr2); end
    checks++; if (wr_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got wr_en=%b done=%b want 0/0", wr_en, done); end
  endtask

  task automatic test_add();
    int wc, dn, dc, rc; logic [3:0] wa, fl; logic [31:0] wd;
    issue(OP_ADD, 1'b1, 4'd3, 4'd1, 4'd2, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (wc !== 3) begin errors++; $display("FAIL add_wr_cycle got %0d want 3", wc); end
    checks++; if (wa !== 4'd3) begin errors++; $display("FAIL add_waddr got %0d want 3", wa); end
    checks++; if (wd !== 32'd12) begin errors++; $display("FAIL add_wdata got %h want 0000000c", wd); end
    checks++; if (fl !== 4'b0000) begin errors++; $display("FAIL add_flags got %b want 0000", fl); end
    checks++; if (dn !== 1 || dc !== 3) begin errors++; $display("FAIL add_done got count=%0d cyc=%0d want 1/3", dn, dc); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL add_ready_return got %0d want 4", rc); end
    checks++; if (rf[3] !== 32'd12) begin errors++; $display("FAIL add_rf3 got %h want 0000000c", rf[3]); end
  endtask

  task automatic test_sub();
    int wc, dn, dc, rc; logic [3:0] wa, fl; logic [31:0] wd;
    issue(OP_SUB, 1'b1, 4'd11, 4'd4, 4'd5, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (wd !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_3m5_data got %h want fffffffe", wd); end
    checks++; if (fl !== 4'b1000) begin errors++; $display("FAIL sub_3m5_flags got %b want 1000", fl); end
    issue(OP_SUB, 1'b1, 4'd12, 4'd5, 4'd5, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (wd !== 32'd0 || wa !== 4'd12) begin errors++; $display("FAIL sub_5m5_data got %h@%0d want 0@12", wd, wa); end
    checks++; if (fl !== 4'b0110) begin errors++; $display("FAIL sub_5m5_flags got %b want 0110", fl); end
  endtask

  task automatic test_add_overflow();
    int wc, dn, dc, rc; logic [3:0] wa, fl; logic [31:0] wd;
    issue(OP_ADD, 1'b1, 4'd13, 4'd6, 4'd7, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (wd !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_data got %h want 80000000", wd); end
    checks++; if (fl !== 4'b1001) begin errors++; $display("FAIL add_ovf_flags got %b want 1001", fl); end
    issue(OP_ADD, 1'b1, 4'd14, 4'd8, 4'd7, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (wd !== 32'd0 || wc !== 3) begin errors++; $display("FAIL add_wrap_data got %h cyc=%0d want 0 cyc=3", wd, wc); end
    checks++; if (fl !== 4'b0110) begin errors++; $display("FAIL add_wrap_flags got %b want 0110", fl); end
  endtask

  task automatic test_compare();
    int wc, dn, dc, rc; logic [3:0] wa, fl; logic [31:0] wd;
    issue(OP_AND, 1'b0, 4'd9, 4'd9, 4'd10, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (wc !== 0) begin errors++; $display("FAIL cmp_no_write got wr at cycle %0d want none", wc); end
    checks++; if (fl !== 4'b0100) begin errors++; $display("FAIL cmp_flags got %b want 0100", fl); end
    checks++; if (dn !== 1 || dc !== 3) begin errors++; $display("FAIL cmp_done got count=%0d cyc=%0d want 1/3", dn, dc); end
    checks++; if (rf[9] !== 32'h0000_00F0) begin errors++; $display("FAIL cmp_rf9 got %h want 000000f0", rf[9]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3] = '{OP_ADD, OP_OR, OP_ADD};
    logic [3:0]  rds [3] = '{4'd15, 4'd2, 4'd15};
    logic [3:0]  rns [3] = '{4'd1, 4'd9, 4'd15};
    logic [3:0]  rms [3] = '{4'd2, 4'd10, 4'd2};
    int          hs  [3] = '{-1, -1, -1};
    int          wc  [3] = '{-1, -1, -1};
    logic [3:0]  wa  [3];
    logic [31:0] wd  [3];
    int nh = 0, nw = 0;
    logic took;
    @(negedge clk);
    cmd_op = ops[0]; cmd_wb = 1'b1; cmd_rd = rds[0]; cmd_rn = rns[0]; cmd_rm = rms[0];
    cmd_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      took = 1'b0;
      if (wr_en === 1'b1 && nw < 3) begin
        wc[nw] = c; wa[nw] = write_addr; wd[nw] = write_data; nw++;
      end
      if (cmd_valid && cmd_ready === 1'b1 && nh < 3) begin
        hs[nh] = c; nh++; took = 1'b1;
      end
      @(posedge clk);
      #1;
      if (took) begin
        if (nh < 3) begin
          cmd_op = ops[nh]; cmd_rd = rds[nh]; cmd_rn = rns[nh]; cmd_rm = rms[nh];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++; if (hs[0] !== 0 || hs[1] !== 4 || hs[2] !== 8) begin
      errors++; $display("FAIL b2b_handshakes got %0d,%0d,%0d want 0,4,8", hs[0], hs[1], hs[2]); end
    checks++; if (wc[0] !== 3 || wc[1] !== 7 || wc[2] !== 11) begin
      errors++; $display("FAIL b2b_write_cycles got %0d,%0d,%0d want 3,7,11", wc[0], wc[1], wc[2]); end
    checks++; if (nw !== 3 || wa[0] !== 4'd15 || wd[0] !== 32'd12) begin
      errors++; $display("FAIL b2b_cmd1 got n=%0d r%0d=%h want n=3 r15=0000000c", nw, wa[0], wd[0]); end
    checks++; if (wa[1] !== 4'd2 || wd[1] !== 32'h0000_00FF) begin
      errors++; $display("FAIL b2b_cmd2 got r%0d=%h want r2=000000ff", wa[1], wd[1]); end
    checks++; if (wa[2] !== 4'd15 || wd[2] !== 32'h0000_010B) begin
      errors++; $display("FAIL b2b_cmd3 got r%0d=%h want r15=0000010b", wa[2], wd[2]); end
    checks++; if (rf[15] !== 32'h0000_010B || flags !== 4'b0000) begin
      errors++; $display("FAIL b2b_final got rf15=%h flags=%b want 0000010b/0000", rf[15], flags); end
  endtask

  task automatic test_reset_abort();
    int wc, dn, dc, rc; logic [3:0] wa, fl; logic [31:0] wd;
    // Flags-only compare leaves N set, so clearing by reset is observable.
    issue(OP_SUB, 1'b0, 4'd0, 4'd4, 4'd5, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (fl !== 4'b1000) begin errors++; $display("FAIL abort_setup1_flags got %b want 1000", fl); end
    // Abort in EXEC.
    @(negedge clk);
    cmd_op = OP_SUB; cmd_wb = 1'b1; cmd_rd = 4'd4; cmd_rn = 4'd4; cmd_rm = 4'd5;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || wr_en !== 1'b0) begin
      errors++; $display("FAIL abort_exec_ctl got ready=%b done=%b wr_en=%b want 1/0/0", cmd_ready, done, wr_en); end
    checks++; if (flags !== 4'b0000 || rf[4] !== 32'd3) begin
      errors++; $display("FAIL abort_exec_state got flags=%b rf4=%h want 0000/00000003", flags, rf[4]); end
    issue(OP_SUB, 1'b0, 4'd0, 4'd4, 4'd5, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (fl !== 4'b1000) begin errors++; $display("FAIL abort_setup2_flags got %b want 1000", fl); end
    // Abort in WB.
    @(negedge clk);
    cmd_op = OP_SUB; cmd_wb = 1'b1; cmd_rd = 4'd4; cmd_rn = 4'd4; cmd_rm = 4'd5;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_wb_strobes got wr_en=%b done=%b want 0/0", wr_en, done); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || flags !== 4'b0000) begin
      errors++; $display("FAIL abort_wb_state got ready=%b flags=%b want 1/0000", cmd_ready, flags); end
    checks++; if (rf[4] !== 32'd3) begin errors++; $display("FAIL abort_wb_rf4 got %h want 00000003", rf[4]); end
    // Engine must run normally after an abort: r4 = 3 + 5.
    issue(OP_ADD, 1'b1, 4'd4, 4'd4, 4'd5, wc, wa, wd, dn, dc, rc, fl);
    checks++; if (wd !== 32'd8 || rf[4] !== 32'd8 || dn !== 1) begin
      errors++; $display("FAIL abort_recover got wd=%h rf4=%h done=%0d want 8/8/1", wd, rf[4], dn); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_add_overflow();
    test_compare();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
